// File: rtl/tile_rom_arb_pkg.sv
// Shared widths, ROM latency default and sizing helper for the tile ROM arbiter.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package tile_rom_arb_pkg;

    localparam int TILE_ADDR_W  = 8;
    localparam int TILE_DATA_W  = 24;
    localparam int TILE_ROM_LAT = 2;

    // Index width for n items, never below one bit so a 1- or 2-entry id still exists.
    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/tile_rom_arbiter_rr_pick.sv
// Combinational round-robin picker: first asserted req at or after ptr, wrapping.
// Latency: 0 cycles (pure combinational).
// Backpressure: none; grant only reflects the current request vector.
import tile_rom_arb_pkg::*;

module rr_pick #(
    parameter int N_REQ = 2,
    parameter int ID_W  = clog2_min1(N_REQ)
) (
    input  logic [N_REQ-1:0] req,
    input  logic [ID_W-1:0]  ptr,
    output logic [N_REQ-1:0] gnt,
    output logic [ID_W-1:0]  gnt_id,
    output logic             any_gnt
);

    always_comb begin
        gnt     = '0;
        gnt_id  = '0;
        any_gnt = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (!any_gnt && req[(int'(ptr) + i) % N_REQ]) begin
                gnt[(int'(ptr) + i) % N_REQ] = 1'b1;
                gnt_id  = ID_W'((int'(ptr) + i) % N_REQ);
                any_gnt = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tile_rom_arbiter.sv
// Round-robin share of one tile-pixel ROM; tagged response routed back as a one-cycle pulse.
// Latency: ROM_LAT+1 cycles handshake edge to o_valid; one access per cycle.
// Backpressure: none past the grant; optional stall counter under TILE_ROM_ARB_STALL_CNT_EN.
import tile_rom_arb_pkg::*;

module tile_rom_arbiter #(
    parameter int N_REQ   = 2,
    parameter int ADDR_W  = TILE_ADDR_W,
    parameter int DATA_W  = TILE_DATA_W,
    parameter int ROM_LAT = TILE_ROM_LAT
) (
    input  logic                      i_clk,
    input  logic                      i_rst_n,
    input  logic [N_REQ-1:0]          i_req,
    input  logic [N_REQ*ADDR_W-1:0]   i_addr,
    output logic [N_REQ-1:0]          o_gnt,
    output logic [N_REQ-1:0]          o_valid,
    output logic [DATA_W-1:0]         o_data,
    output logic [ADDR_W-1:0]         o_rom_address,
`ifdef TILE_ROM_ARB_STALL_CNT_EN
    output logic [15:0]               o_stall_cnt,
`endif
    input  logic [DATA_W-1:0]         i_rom_data
);

    localparam int ID_W = clog2_min1(N_REQ);

    logic [ID_W-1:0]  ptr;
    logic [N_REQ-1:0] gnt;
    logic [ID_W-1:0]  gnt_id;
    logic             hs;

    logic [ROM_LAT:0] tag_vld;
    logic [ID_W-1:0]  tag_id [ROM_LAT+1];

    rr_pick #(
        .N_REQ (N_REQ),
        .ID_W  (ID_W)
    ) u_pick (
        .req     (i_req),
        .ptr     (ptr),
        .gnt     (gnt),
        .gnt_id  (gnt_id),
        .any_gnt (hs)
    );

    assign o_gnt = gnt;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            ptr           <= '0;
            o_rom_address <= '0;
        end else if (hs) begin
            o_rom_address <= i_addr[int'(gnt_id)*ADDR_W +: ADDR_W];
            ptr           <= (gnt_id == ID_W'(N_REQ-1)) ? '0 : gnt_id + 1'b1;
        end
    end

    // Stage k of the tag line lines up with the ROM address presented k cycles earlier.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tag_vld <= '0;
            for (int k = 0; k <= ROM_LAT; k++) tag_id[k] <= '0;
        end else begin
            tag_vld   <= {tag_vld[ROM_LAT-1:0], hs};
            tag_id[0] <= gnt_id;
            for (int k = 1; k <= ROM_LAT; k++) tag_id[k] <= tag_id[k-1];
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_valid <= '0;
            o_data  <= '0;
        end else begin
            o_valid <= tag_vld[ROM_LAT] ? (N_REQ'(1) << tag_id[ROM_LAT]) : '0;
            if (tag_vld[ROM_LAT]) o_data <= i_rom_data;
        end
    end

`ifdef TILE_ROM_ARB_STALL_CNT_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_stall_cnt <= '0;
        end else if (|(i_req & ~gnt) && (o_stall_cnt != 16'hFFFF)) begin
            o_stall_cnt <= o_stall_cnt + 16'd1;
        end
    end
`endif

endmodule

// File: doc/tile_rom_arbiter.md
Name: tile_rom_arbiter

Overview:
- Shares one synchronous tile-pixel ROM (8-bit address, 24-bit RGB data) between N_REQ pixel-layer requesters, e.g. background layer and sprite layer.
- Round-robin arbitration, with one accepted access per clock, fully pipelined.
- Returns read data to the originating requester with a one-cycle valid pulse.
- Sits between the layer fetch FSMs and the tile ROM instance.

Parameters:
- N_REQ, 2, number of requesters (2..8)
- ADDR_W, 8, ROM address width
- DATA_W, 24, ROM data width (RGB888)
- ROM_LAT, 2, ROM read latency in cycles: address driven in cycle T gives data on i_rom_data in cycle T+ROM_LAT (1..4)

Ports:
- i_clk  in  1  system clock; all logic on posedge
- i_rst_n  in  1  asynchronous active-low reset
- i_req  in  N_REQ  per-requester read request; held until granted
- i_addr  in  N_REQ*ADDR_W  per-requester address; slice k = [k*ADDR_W +: ADDR_W]; stable while i_req[k] high
- o_gnt  out  N_REQ  combinational one-hot grant; at most one bit high
- o_valid  out  N_REQ  registered one-hot response pulse
- o_data  out  DATA_W  registered response data; meaningful only when any o_valid bit is high
- o_rom_address  out  ADDR_W  registered ROM address
- i_rom_data  in  DATA_W  ROM read data

Behaviour:
Reset values:
- While i_rst_n is low: o_valid=0, o_data=0, o_rom_address=0.
- Round-robin pointer=0, so requester 0 has highest priority.
- All in-flight tags are cleared.

Arbitration:
- Combinational picker selects the first asserted i_req[k] searching k=ptr, ptr+1, …, wrapping modulo N_REQ.
- o_gnt[k] is high for the selected k only; o_gnt=0 when i_req=0.
- A handshake completes at a clock edge where i_req[k] and o_gnt[k] are both high.
- On handshake: o_rom_address <= i_addr slice k, and ptr <= (k+1) mod N_REQ.
- With no handshake, ptr and o_rom_address hold their values.
- A requester may drop i_req, or present a new address, in the cycle after its handshake. Back-to-back grants to the same requester are legal when it is the only requester.

Tag pipeline:
- A ROM_LAT+1 deep shift register carries {valid, id}, where id width = clog2(N_REQ), min 1.
- It is loaded at the handshake edge and shifts every cycle; there is no stall and no backpressure.
- At the edge ending cycle G+ROM_LAT (G = cycle o_rom_address first shows the new address): o_data <= i_rom_data and o_valid <= onehot(id).
- The response is therefore visible in cycle G+ROM_LAT+1. Latency from handshake edge to o_valid high is ROM_LAT+1 cycles.
- o_valid is high for exactly one cycle per accepted request. Responses return in acceptance order.
- o_data holds its last value when no response is pending.

Boundary conditions:
- All requesters active: each is granted once every N_REQ cycles; throughput is 1 access per cycle.
- Wrap-around: after a grant to N_REQ-1, ptr becomes 0.
- Asynchronous reset mid-flight: all pending responses are discarded; no o_valid is generated for them after reset release.
- i_req without a handshake never changes state.

Optional Feature:
- Macro: TILE_ROM_ARB_STALL_CNT_EN
- Defined: adds output o_stall_cnt, 16 bits, reset 0.
  - Increments by 1 on every edge where i_req has a bit high that is not granted (at least one requester waiting).
  - Saturates at 16'hFFFF.
  - Cleared only by reset.
- Undefined: the port and counter do not exist; all other behaviour is identical.

Decomposition:
- Shared package tile_rom_arb_pkg holds:
  - default widths TILE_ADDR_W=8 and TILE_DATA_W=24;
  - TILE_ROM_LAT=2;
  - function clog2_min1(n).
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req[N_REQ], ptr.
  - Outputs: one-hot gnt, encoded gnt_id, any_gnt.
  - Reusable by a future LCD bus arbiter.

Test Plan:
- Reset check: hold i_rst_n=0 with i_req=2'b11 -> o_valid=0, o_rom_address=0, o_gnt=2'b01 (combinational, ptr=0).
- Single requester: ROM model mem[a]=a*24'h010101; i_req[0]=1 with addr 8'h05 for one handshake -> o_rom_address=8'h05 next cycle; o_valid=2'b01 with o_data=24'h050505 exactly 3 cycles after the handshake edge (ROM_LAT=2).
- Contention fairness: i_req=2'b11 held, addr0=8'h10, addr1=8'h20, for 8 cycles -> grants alternate 01,10,01,…; responses 24'h101010 then 24'h202020 alternating in order, one per cycle.
- Streaming back-to-back: requester 1 alone, addresses 0..15 on consecutive cycles -> 16 consecutive o_valid=2'b10 pulses with o_data=mem[0..15] and no gaps.
- Reset mid-flight: two accepted requests, then i_rst_n low for 1 cycle before the responses return -> no o_valid pulse afterward; next grant goes to requester 0.
- Feature check (TILE_ROM_ARB_STALL_CNT_EN defined): i_req=2'b11 for 10 cycles -> o_stall_cnt=10. Force 70000 stall cycles -> o_stall_cnt=16'hFFFF.
